// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to a variable-latency imem, buffers returns for decode.
// Latency: redirect at N -> request N+1; with 1-cycle memory and gnt=1, if_valid_o at N+3; one instruction per cycle steady state.
// Backpressure: id_ready_i low fills the DEPTH-entry buffer, then imem_req_o drops; ungranted requests hold address stable.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   imem_req_o/addr_o   fetch request (address = pc[31:0]); accepted on imem_gnt_i
//   imem_rvalid_i/rdata in-order instruction responses
//   redirect_i/pc_i     flush buffered and in-flight fetches, restart at redirect_pc_i
//   if_valid_o/instr_o/pc_o, id_ready_i   valid/ready handoff to decode
//   perf_fetched_o, perf_stall_o          present only when FETCH_PERF_EN is defined
// Optional feature macro: FETCH_PERF_EN (decode-transfer and decode-starved cycle counters).

module fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [31:0]     imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            id_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Fetch PC and slot storage.
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_slot_pc    [DEPTH];
  logic [31:0]      r_slot_instr [DEPTH];
  logic [DEPTH-1:0] r_slot_filled;

  // head: next to decode; tail: next to allocate; fill: oldest allocated-but-unfilled.
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_fill;

  // alloc: slots holding a granted fetch; pend: allocated slots still waiting on data;
  // drop: responses still owed by memory for fetches that were flushed.
  logic [CW-1:0] r_alloc_cnt;
  logic [CW-1:0] r_pend_cnt;
  logic [CW-1:0] r_drop_cnt;

  // Last presented head values, so outputs hold while nothing is valid.
  logic [31:0]     r_last_instr;
  logic [XLEN-1:0] r_last_pc;

  logic          w_grant;
  logic          w_head_ok;
  logic          w_xfer;
  logic          w_fill;
  logic          w_drop_rsp;
  logic [CW:0]   w_occ;
  logic [CW:0]   w_inflight;
  logic [CW:0]   w_redir_drop;

  // Outstanding responses (stale + live) never exceed DEPTH because drop+alloc gates the request.
  assign w_occ      = {1'b0, r_drop_cnt} + {1'b0, r_alloc_cnt};
  assign w_inflight = {1'b0, r_drop_cnt} + {1'b0, r_pend_cnt};

  assign imem_req_o  = (r_alloc_cnt < CW'(DEPTH)) && (w_occ < (CW+1)'(DEPTH)) && !redirect_i && rst;
  assign imem_addr_o = r_pc[31:0];
  assign w_grant     = imem_req_o && imem_gnt_i;

  assign w_head_ok  = (r_alloc_cnt != '0) && r_slot_filled[r_head];
  assign if_valid_o = w_head_ok && !redirect_i;
  assign if_instr_o = w_head_ok ? r_slot_instr[r_head] : r_last_instr;
  assign if_pc_o    = w_head_ok ? r_slot_pc[r_head]    : r_last_pc;
  assign w_xfer     = if_valid_o && id_ready_i;

  // A response belongs to a flushed fetch while drop_cnt is nonzero; older responses always come first.
  assign w_drop_rsp = imem_rvalid_i && (r_drop_cnt != '0);
  assign w_fill     = imem_rvalid_i && (r_drop_cnt == '0) && (r_pend_cnt != '0) && !redirect_i;

  // On redirect every unfilled slot becomes a response to discard; a response landing
  // in the redirect cycle itself is already consumed, so it is not counted.
  always_comb begin
    w_redir_drop = w_inflight;
    if (imem_rvalid_i && (w_inflight != '0)) begin
      w_redir_drop = w_inflight - (CW+1)'(1);
    end
    if (w_redir_drop > (CW+1)'(DEPTH)) begin
      w_redir_drop = (CW+1)'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_slot_filled <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_fill        <= '0;
      r_alloc_cnt   <= '0;
      r_pend_cnt    <= '0;
      r_drop_cnt    <= '0;
      r_last_instr  <= '0;
      r_last_pc     <= '0;
    end else begin
      if (w_head_ok) begin
        r_last_instr <= r_slot_instr[r_head];
        r_last_pc    <= r_slot_pc[r_head];
      end
      if (redirect_i) begin
        r_pc          <= redirect_pc_i;
        r_slot_filled <= '0;
        r_head        <= '0;
        r_tail        <= '0;
        r_fill        <= '0;
        r_alloc_cnt   <= '0;
        r_pend_cnt    <= '0;
        r_drop_cnt    <= w_redir_drop[CW-1:0];
      end else begin
        if (w_grant) begin
          r_slot_filled[r_tail] <= 1'b0;
          r_tail                <= r_tail + PW'(1);
          r_pc                  <= r_pc + XLEN'(PC_INC);
        end
        if (w_fill) begin
          r_slot_filled[r_fill] <= 1'b1;
          r_fill                <= r_fill + PW'(1);
        end
        if (w_xfer) begin
          r_head <= r_head + PW'(1);
        end
        if (w_drop_rsp) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        case ({w_grant, w_xfer})
          2'b10:   r_alloc_cnt <= r_alloc_cnt + CW'(1);
          2'b01:   r_alloc_cnt <= r_alloc_cnt - CW'(1);
          default: r_alloc_cnt <= r_alloc_cnt;
        endcase
        case ({w_grant, w_fill})
          2'b10:   r_pend_cnt <= r_pend_cnt + CW'(1);
          2'b01:   r_pend_cnt <= r_pend_cnt - CW'(1);
          default: r_pend_cnt <= r_pend_cnt;
        endcase
      end
    end
  end

  // Payload storage needs no reset: the filled bits and counters decide what is visible.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_slot_pc[r_tail] <= r_pc;
    end
    if (w_fill) begin
      r_slot_instr[r_fill] <= imem_rdata_i;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else if (!redirect_i) begin
      if (w_xfer) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (id_ready_i && !if_valid_o) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_stall_o   = r_perf_stall;
`endif

endmodule
